// File: rtl/id_hazard_stage_pkg.sv
// Shared encodings for the decode-stage hazard/branch back end.
package id_hazard_stage_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } brType_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwdSel_e;

  // Every bit of a bubbled control bundle takes this value.
  localparam logic BUBBLE_CTRL_BIT = 1'b0;

  function automatic logic isBranch(input logic [2:0] brType);
    return (brType >= 3'd1) && (brType <= 3'd6);
  endfunction

endpackage

// File: rtl/id_hazard_stage_branch_cmp.sv
// Branch condition evaluator: signed compare of forwarded operands.
module branch_cmp
  import id_hazard_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        brType,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken
);

  logic aNeg;
  logic aZero;

  always_comb begin
    aNeg  = a[DATA_W-1];
    aZero = (a == '0);
    taken = 1'b0;
    case (brType_e'(brType))
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLEZ: taken = aNeg || aZero;
      BR_BGTZ: taken = !aNeg && !aZero;
      BR_BLTZ: taken = aNeg;
      BR_BGEZ: taken = !aNeg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_hazard_stage.sv
// Decode-stage back end: hazard detection, branch resolution with M/W
// forwarding, ID/EX pipeline register and saturating stall counter.
module id_hazard_stage
  import id_hazard_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CTRL_W      = 16,
  parameter int unsigned DELAY_SLOT  = 1,
  parameter int unsigned WB_BYPASS   = 1,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   validD,
  input  logic [REG_ADDR_W-1:0]  rsD,
  input  logic [REG_ADDR_W-1:0]  rtD,
  input  logic [REG_ADDR_W-1:0]  rdD,
  input  logic                   usesRsD,
  input  logic                   usesRtD,
  input  logic [DATA_W-1:0]      readData1D,
  input  logic [DATA_W-1:0]      readData2D,
  input  logic [15:0]            imm16D,
  input  logic [CTRL_W-1:0]      ctrlD,
  input  logic [2:0]             brTypeD,
  input  logic [REG_ADDR_W-1:0]  writeRegE,
  input  logic                   regWriteE,
  input  logic                   memToRegE,
  input  logic [REG_ADDR_W-1:0]  writeRegM,
  input  logic                   regWriteM,
  input  logic                   memToRegM,
  input  logic [DATA_W-1:0]      aluOutM,
  input  logic [REG_ADDR_W-1:0]  writeRegW,
  input  logic                   regWriteW,
  input  logic [DATA_W-1:0]      wbOutW,
  input  logic                   flushE,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   flushD,
  output logic                   branchTakenD,
  output logic [1:0]             forwardAD,
  output logic [1:0]             forwardBD,
  output logic                   validE,
  output logic [REG_ADDR_W-1:0]  rsE,
  output logic [REG_ADDR_W-1:0]  rtE,
  output logic [REG_ADDR_W-1:0]  rdE,
  output logic [DATA_W-1:0]      readData1E,
  output logic [DATA_W-1:0]      readData2E,
  output logic [15:0]            imm16E,
  output logic [CTRL_W-1:0]      ctrlE,
  output logic [STALL_CNT_W-1:0] stallCount
);

  logic              matchE;
  logic              matchM;
  logic              loadUse;
  logic              brHaz;
  logic              stall;
  fwdSel_e           fwdA;
  fwdSel_e           fwdB;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              condTaken;

  // Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    matchE = (writeRegE != '0) &&
             ((usesRsD && (rsD == writeRegE)) || (usesRtD && (rtD == writeRegE)));
    matchM = (writeRegM != '0) &&
             ((usesRsD && (rsD == writeRegM)) || (usesRtD && (rtD == writeRegM)));
    loadUse = validE && memToRegE && matchE;
    brHaz   = isBranch(brTypeD) &&
              ((regWriteE && matchE) || (regWriteM && memToRegM && matchM));
    stall   = validD && (loadUse || brHaz);
  end

  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    if (regWriteM && !memToRegM && (rsD != '0) && (writeRegM == rsD))
      fwdA = FWD_M;
    else if ((WB_BYPASS != 0) && regWriteW && (rsD != '0) && (writeRegW == rsD))
      fwdA = FWD_W;
    if (regWriteM && !memToRegM && (rtD != '0) && (writeRegM == rtD))
      fwdB = FWD_M;
    else if ((WB_BYPASS != 0) && regWriteW && (rtD != '0) && (writeRegW == rtD))
      fwdB = FWD_W;
  end

  always_comb begin
    case (fwdA)
      FWD_M:   opA = aluOutM;
      FWD_W:   opA = wbOutW;
      default: opA = readData1D;
    endcase
    case (fwdB)
      FWD_M:   opB = aluOutM;
      FWD_W:   opB = wbOutW;
      default: opB = readData2D;
    endcase
  end

  branch_cmp #(.DATA_W(DATA_W)) uCmp (
    .brType (brTypeD),
    .a      (opA),
    .b      (opB),
    .taken  (condTaken)
  );

  always_comb begin
    stallF       = stall;
    stallD       = stall;
    forwardAD    = fwdA;
    forwardBD    = fwdB;
    branchTakenD = validD && !stall && condTaken;
    flushD       = branchTakenD && (DELAY_SLOT == 0);
  end

  // A stall re-inserts a bubble every stalled cycle; D holds the instruction.
  always_ff @(posedge clk) begin
    if (rst || flushE || stall) begin
      validE     <= 1'b0;
      rsE        <= '0;
      rtE        <= '0;
      rdE        <= '0;
      readData1E <= '0;
      readData2E <= '0;
      imm16E     <= '0;
      ctrlE      <= {CTRL_W{BUBBLE_CTRL_BIT}};
    end else begin
      validE     <= validD;
      rsE        <= rsD;
      rtE        <= rtD;
      rdE        <= rdD;
      readData1E <= readData1D;
      readData2E <= readData2D;
      imm16E     <= imm16D;
      ctrlE      <= validD ? ctrlD : {CTRL_W{BUBBLE_CTRL_BIT}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stallCount <= '0;
    else if (stall && (stallCount != '1))
      stallCount <= stallCount + STALL_CNT_W'(1);
  end

endmodule

// File: doc/id_hazard_stage.md
Name: id_hazard_stage

Overview:
- Parametrised decode-stage back end for the 5-stage MIPS pipeline.
- Sits between register-file read/control decode (D) and execute (E).
- Resolves branches in D over six branch types, forwarding from M and W.
- Detects load-use and branch-operand hazards, generates stall/flush, owns the ID/EX pipeline register and a saturating stall counter.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- CTRL_W, 16, width of the opaque control bundle carried D->E.
- DELAY_SLOT, 1: 1 = branch delay slot, no IF/ID flush; 0 = flush IF/ID on a taken branch.
- WB_BYPASS, 1: 1 = forward W-stage result to the branch comparator; 0 = rely on the regfile write-before-read.
- STALL_CNT_W, 32, stall counter width.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- validD in 1: D holds a real instruction.
- rsD, rtD, rdD in REG_ADDR_W: decoded register fields.
- usesRsD, usesRtD in 1: instruction reads rs / rt.
- readData1D, readData2D in DATA_W: regfile read data.
- imm16D in 16: immediate.
- ctrlD in CTRL_W: control bundle from the control unit.
- brTypeD in 3: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none).
- writeRegE in REG_ADDR_W; regWriteE in 1; memToRegE in 1: E destination info.
- writeRegM in REG_ADDR_W; regWriteM in 1; memToRegM in 1; aluOutM in DATA_W: M destination info and result.
- writeRegW in REG_ADDR_W; regWriteW in 1; wbOutW in DATA_W: W destination info and result.
- flushE in 1: external request to bubble E next cycle.
- stallF, stallD out 1: hold PC and IF/ID.
- flushD out 1: clear IF/ID.
- branchTakenD out 1: select branch target in the NPC.
- forwardAD, forwardBD out 2: 0 regfile, 1 M, 2 W.
- validE out 1; rsE, rtE, rdE out REG_ADDR_W; readData1E, readData2E out DATA_W; imm16E out 16; ctrlE out CTRL_W: registered ID/EX outputs.
- stallCount out STALL_CNT_W: cycles stalled.

Behaviour:
- Reset: all E outputs, validE, ctrlE and stallCount are 0. Combinational outputs follow their equations.
- match(X) = X != 0 and ((usesRsD and rsD == X) or (usesRtD and rtD == X)). Register 0 never matches or forwards.
- loadUse = validE and memToRegE and match(writeRegE).
- brHaz = brTypeD in 1..6 and one of:
  - regWriteE and match(writeRegE);
  - regWriteM and memToRegM and match(writeRegM).
- stall = validD and (loadUse or brHaz). stallF = stallD = stall.
- Forward select for rs (rt identical):
  - 1 if regWriteM and !memToRegM and writeRegM == rsD != 0;
  - else 2 if WB_BYPASS and regWriteW and writeRegW == rsD != 0;
  - else 0.
- Compare operands: a = forwarded rs, b = forwarded rt, both signed.
  - beq: a == b; bne: a != b.
  - blez: a <= 0; bgtz: a > 0; bltz: a < 0; bgez: a >= 0.
  - Single-operand types (blez..bgez) ignore b.
- branchTakenD = validD and !stall and condition. flushD = branchTakenD and (DELAY_SLOT == 0).
- ID/EX register updates every clock, priority order:
  - rst: all zero.
  - flushE or stall: bubble. validE = 0, ctrlE = 0, other fields don't-care (driven 0).
  - otherwise: load D values; validE = validD; if validD = 0, ctrlE = 0.
- Latency: exactly 1 cycle D -> E. No multi-cycle holding; the stall bubble repeats each stalled cycle.
- stallCount: increments every cycle stall = 1; saturates at all-ones; cleared only by rst.
- flushE concurrent with stall: stall outputs still assert and a bubble is inserted (same result).
- Reset mid-stall: next cycle stall is re-evaluated from inputs and E holds a bubble.

Decomposition:
- Shared defines header holds the brType encodings, forward-select encodings (FWD_RF/FWD_M/FWD_W) and the bubble ctrl value.
- Sub-module branch_cmp (combinational, DATA_W-parametrised, brType + a + b -> taken).
- Hazard logic and the ID/EX register stay in the top module.

Test Plan:
- Load-use: lw writes $8 (validE=1, memToRegE=1, writeRegE=8); D add uses rs=8 -> stallF=stallD=1, next cycle validE=0, ctrlE=0, stallCount=1.
- Branch with M forwarding: beq rs=3 rt=4, regWriteM=1, writeRegM=3, aluOutM=5, readData2D=5 -> forwardAD=1, forwardBD=0, branchTakenD=1, no stall.
- Branch on E ALU result: bne rs=9, regWriteE=1, writeRegE=9 -> stall=1 for one cycle. Once the producer reaches M with aluOutM=0 and rt value 0, branchTakenD=0.
- Signed types: rs value 0xFFFFFFFF -> bltz taken, bgez not, blez taken, bgtz not. rs value 0 -> blez and bgez taken.
- $0 and DELAY_SLOT:
  - regWriteM=1, writeRegM=0, rsD=0 -> forwardAD=0, no stall.
  - With DELAY_SLOT=0, a taken beq gives flushD=1; with DELAY_SLOT=1, flushD=0.
- Saturation and reset: STALL_CNT_W=3, hold the stall for 10 cycles -> stallCount=7; assert rst -> stallCount=0, validE=0 the next cycle.
